// File: rtl/tsv_repair_ctrl.sv
// tsv_repair_ctrl: BIST and spare-TSV repair sequencer for the 9-TSV CAC/AFNS link
module tsv_repair_ctrl #(
    parameter int N_TSV      = 9,
    parameter int N_RED      = 3,
    parameter int SETTLE_CYC = 2,
    parameter int DRAIN_TO   = 16
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_link_idle,
    input  logic [N_TSV-1:0]             i_tsv_sense,
    output logic                         o_link_hold,
    output logic                         o_test_en,
    output logic [N_TSV-1:0]             o_tsv_drive,
    output logic [N_TSV-1:0]             o_f_flag,
    output logic [$clog2(N_TSV+1)-1:0]   o_fault_cnt,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_fail,
    output logic                         o_drain_err
);
    localparam int FW   = $clog2(N_TSV + 1);
    localparam int CMAX = DRAIN_TO > SETTLE_CYC ? DRAIN_TO : SETTLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_DRIVE, S_SAMPLE, S_EVAL, S_UPDATE, S_SETTLE, S_FAIL
    } state_t;

    // P0 all zero, P1 all one, P2 odd bits set, P3 even bits set
    function automatic logic [N_TSV-1:0] f_pat(input logic [1:0] k);
        logic [N_TSV-1:0] a;
        for (int i = 0; i < N_TSV; i++) a[i] = i[0];
        return k == 2'd0 ? '0 : k == 2'd1 ? '1 : k == 2'd2 ? a : ~a;
    endfunction

    state_t           r_state, w_next;
    logic [1:0]       r_k, w_k_nxt;
    logic [CW-1:0]    r_cnt;
    logic [N_TSV-1:0] r_acc, r_f_flag, r_tsv_drive, w_tsv_drive, w_m;
    logic [FW-1:0]    r_fault_cnt, w_pc;
    logic             r_link_hold, r_test_en, r_busy, r_done, r_fail, r_drain_err;
    logic             w_link_hold, w_test_en, w_busy, w_done, w_fail, w_drain_err;

    assign w_m = r_f_flag | r_acc;
    assign w_pc = FW'($countones(w_m));

    // State register; outputs are registered from the next-state decode so they line up with the state
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_link_hold <= 1'b0;
            r_test_en   <= 1'b0;
            r_tsv_drive <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_drain_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_link_hold <= w_link_hold;
            r_test_en   <= w_test_en;
            r_tsv_drive <= w_tsv_drive;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_fail      <= w_fail;
            r_drain_err <= w_drain_err;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FAIL: if (i_start) w_next = S_DRAIN;
            S_DRAIN:        w_next = i_link_idle ? S_DRIVE : r_cnt == CW'(1) ? S_IDLE : S_DRAIN;
            S_DRIVE:        w_next = S_SAMPLE;
            S_SAMPLE:       w_next = r_k == 2'd3 ? S_EVAL : S_DRIVE;
            S_EVAL:         w_next = w_pc > FW'(N_RED) ? S_FAIL : S_UPDATE;
            S_UPDATE:       w_next = S_SETTLE;
            S_SETTLE:       if (r_cnt == CW'(1)) w_next = S_IDLE;
            default:        w_next = S_IDLE;
        endcase
    end

    // Output decode for the state being entered; k advances as SAMPLE hands over to the next DRIVE
    always_comb begin
        w_k_nxt     = r_state == S_SAMPLE ? r_k + 2'd1 : w_next == S_DRAIN ? 2'd0 : r_k;
        w_link_hold = w_next != S_IDLE;
        w_test_en   = w_next == S_DRIVE || w_next == S_SAMPLE;
        w_tsv_drive = w_test_en ? f_pat(w_k_nxt) : '0;
        w_busy      = w_next != S_IDLE && w_next != S_FAIL;
        w_fail      = w_next == S_FAIL;
        w_done      = r_state == S_SETTLE && w_next == S_IDLE;
        w_drain_err = r_state == S_DRAIN && w_next == S_IDLE;
    end

    // Pattern index, shared drain/settle counter, mismatch accumulator and the sticky fault map
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_k         <= 2'd0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_f_flag    <= '0;
            r_fault_cnt <= '0;
        end else begin
            r_k <= w_k_nxt;
            if (w_next == S_DRAIN && r_state != S_DRAIN) begin
                r_cnt <= CW'(DRAIN_TO);
                r_acc <= '0;
            end else if (r_state == S_UPDATE) begin
                r_cnt <= CW'(SETTLE_CYC);
            end else if (r_state == S_DRAIN || r_state == S_SETTLE) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (r_state == S_SAMPLE) r_acc <= r_acc | (i_tsv_sense ^ r_tsv_drive);
            if (r_state == S_EVAL) r_fault_cnt <= w_pc;
            if (r_state == S_UPDATE) r_f_flag <= w_m;
        end
    end

    assign o_link_hold = r_link_hold;
    assign o_test_en   = r_test_en;
    assign o_tsv_drive = r_tsv_drive;
    assign o_f_flag    = r_f_flag;
    assign o_fault_cnt = r_fault_cnt;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_fail      = r_fail;
    assign o_drain_err = r_drain_err;
endmodule
